mul_seq_32b: RTL and testbench

MUL_SEQ_32B -- requirements
Module: mul_seq_32b

---
 rtl/mul_pkg.sv | 13 +
 rtl/adder_32b.sv | 12 +
 rtl/mul_seq_32b.sv | 93 +++++++++
 tb/tb_mul_seq_32b.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned N_ITER = 32;
  localparam logic [4:0]  CNT_LAST = 5'(N_ITER - 1);

endpackage

// File: rtl/adder_32b.sv
// 32-bit ripple adder with carry in/out; the multiplier's only adder.
module adder_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mul_seq_32b.sv
// Unsigned 32x32 -> 64 shift-add multiplier, one partial product per clock.
// state | meaning
// IDLE  | waiting for start, product holds last result
// RUN   | 32 shift-add iterations, cnt counts them
// DONE  | one-cycle done pulse, product final
module mul_seq_32b
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] m_q;
  logic [63:0] p_q;
  logic [63:0] product_q;
  logic [31:0] add_b;
  logic [31:0] sum;
  logic        cout;
  logic [63:0] p_next;
  logic        last_iter;

  // Adding zero when P[0]=0 gives the plain pass-through with c=0.
  assign add_b = p_q[0] ? m_q : 32'h0;

  adder_32b u_adder (
    .a    (p_q[63:32]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign p_next    = {cout, sum, p_q[31:1]};
  assign last_iter = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 5'd0;
      m_q       <= 32'h0;
      p_q       <= 64'h0;
      product_q <= 64'h0;
    end else begin
      if (state_q == IDLE && start) begin
        m_q   <= a;
        p_q   <= {32'h0, b};
        cnt_q <= 5'd0;
      end else if (state_q == RUN) begin
        p_q   <= p_next;
        cnt_q <= cnt_q + 5'd1;
        if (last_iter) product_q <= p_next;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_32b.sv
// Directed and random checks for mul_seq_32b; edges counted from the accepting edge.
module tb_mul_seq_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  mul_seq_32b dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Runs one operation; sampling index e=0 is the negedge right after the accepting edge.
  task automatic do_op(input logic [31:0] ai, input logic [31:0] bi,
                       output logic [63:0] prod, output int done_edge,
                       output int done_cnt, output int busy_cnt, output bit held);
    logic [63:0] prev;
    @(negedge clk);
    prev  = product;
    a     = ai;
    b     = bi;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    done_edge = -1;
    done_cnt  = 0;
    busy_cnt  = 0;
    held      = 1'b1;
    prod      = 64'h0;
    for (int e = 0; e < 100; e++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          prod      = product;
        end
      end else if (done_edge < 0 && product !== prev) begin
        held = 1'b0;
      end
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
    else n_pass++;
    n_checks++;
    if (product !== 64'h0) $display("FAIL reset_product: got %h expected 0", product);
    else n_pass++;
    #23;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] p;
    int de, dc, bc;
    bit h;
    do_op(32'd3, 32'd5, p, de, dc, bc, h);
    n_checks++;
    if (p !== 64'd15) $display("FAIL basic_product: got %0d expected 15", p);
    else n_pass++;
    n_checks++;
    if (de !== 32) $display("FAIL basic_done_edge: got %0d expected 32", de);
    else n_pass++;
    n_checks++;
    if (dc !== 1) $display("FAIL basic_done_count: got %0d expected 1", dc);
    else n_pass++;
    n_checks++;
    if (bc !== 33) $display("FAIL basic_busy_cycles: got %0d expected 33", bc);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (product !== 64'd15 || busy !== 1'b0)
      $display("FAIL basic_hold: got product %0d busy %b expected 15 busy 0", product, busy);
    else n_pass++;
  endtask

  task automatic test_max();
    logic [63:0] p;
    int de, dc, bc;
    bit h;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, de, dc, bc, h);
    n_checks++;
    if (p !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL max_product: got %h expected fffffffe00000001", p);
    else n_pass++;
    n_checks++;
    if (de !== 32) $display("FAIL max_done_edge: got %0d expected 32", de);
    else n_pass++;
  endtask

  task automatic test_zero();
    logic [63:0] p;
    int de, dc, bc;
    bit h;
    do_op(32'h0, 32'h1234_5678, p, de, dc, bc, h);
    n_checks++;
    if (p !== 64'h0 || de !== 32 || bc !== 33)
      $display("FAIL zero_a: got product %h done_edge %0d busy %0d expected 0/32/33", p, de, bc);
    else n_pass++;
    do_op(32'h1234_5678, 32'h0, p, de, dc, bc, h);
    n_checks++;
    if (p !== 64'h0 || de !== 32 || bc !== 33)
      $display("FAIL zero_b: got product %h done_edge %0d busy %0d expected 0/32/33", p, de, bc);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int first_done  = -1;
    int second_done = -1;
    @(negedge clk);
    a     = 32'd7;
    b     = 32'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e <= 68; e++) begin
      if (done && e < 40 && first_done < 0) begin
        first_done = e;
        n_checks++;
        if (product !== 64'd42) $display("FAIL ignore_product: got %0d expected 42", product);
        else n_pass++;
      end
      if (done && e >= 40 && second_done < 0) begin
        second_done = e;
        n_checks++;
        if (product !== 64'd81) $display("FAIL held_start_product: got %0d expected 81", product);
        else n_pass++;
      end
      if (e == 33) begin
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ignore_idle_gap: got busy %b expected 0", busy);
        else n_pass++;
      end
      if (e == 65) begin
        n_checks++;
        if (product !== 64'd42) $display("FAIL ignore_hold: got %0d expected 42", product);
        else n_pass++;
      end
      if (e == 10) begin
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
      end
      if (e == 11) start = 1'b0;
      if (e == 31) start = 1'b1;
      if (e == 34) start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (first_done !== 32 || second_done !== 66)
      $display("FAIL ignore_done_edges: got %0d,%0d expected 32,66", first_done, second_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d_cnt = 0;
    int d_edge[2] = '{-1, -1};
    logic [63:0] d_prod[2] = '{64'h0, 64'h0};
    @(negedge clk);
    a     = 32'd2;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    a = 32'd4;
    b = 32'd5;
    for (int e = 0; e <= 70; e++) begin
      if (done) begin
        if (d_cnt < 2) begin
          d_edge[d_cnt] = e;
          d_prod[d_cnt] = product;
        end
        d_cnt++;
      end
      if (e == 34) start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (d_cnt !== 2) $display("FAIL b2b_done_count: got %0d expected 2", d_cnt);
    else n_pass++;
    n_checks++;
    if (d_edge[0] !== 32 || d_edge[1] !== 66)
      $display("FAIL b2b_period: got %0d,%0d expected 32,66", d_edge[0], d_edge[1]);
    else n_pass++;
    n_checks++;
    if (d_prod[0] !== 64'd6 || d_prod[1] !== 64'd20)
      $display("FAIL b2b_products: got %0d,%0d expected 6,20", d_prod[0], d_prod[1]);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [63:0] p;
    int de, dc, bc;
    bit h;
    int stray = 0;
    @(negedge clk);
    a     = 32'd100;
    b     = 32'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0)
      $display("FAIL abort_immediate: got busy %b done %b product %h expected 0/0/0", busy, done, product);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    n_checks++;
    if (stray !== 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", stray);
    else n_pass++;
    do_op(32'd100, 32'd200, p, de, dc, bc, h);
    n_checks++;
    if (p !== 64'd20000 || de !== 32)
      $display("FAIL abort_restart: got product %0d done_edge %0d expected 20000/32", p, de);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] p;
    logic [63:0] ref_p;
    logic [31:0] ra, rb;
    int de, dc, bc;
    bit h;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'hFFFF_FFFF;
      if (i % 70 == 1) rb = 32'h8000_0001;
      ref_p = {32'h0, ra} * {32'h0, rb};
      do_op(ra, rb, p, de, dc, bc, h);
      n_checks++;
      if (p !== ref_p || de !== 32 || dc !== 1 || !h)
        $display("FAIL rand_%0d: a=%h b=%h got %h edge %0d dones %0d held %0b expected %h edge 32 dones 1 held 1",
                 i, ra, rb, p, de, dc, h, ref_p);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
